// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the execute stage: fixed-latency mult/div with
// deferred commit, plus mthi/mtlo moves when idle.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no operation in flight; accepts start or a move
// S_RUN  | operation in flight; counter runs down, commit at terminal count
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  start,
  input  logic [1:0]  MD,
  input  logic        flush,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;

  localparam logic [1:0] MD_MTHI = 2'd1;
  localparam logic [1:0] MD_MTLO = 2'd3;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_sh, lo_sh;
  logic             skip_sh;

  logic             start_valid, start_ok, md_ok, commit, cnt_last;
  logic             is_mul, signed_op, div_zero;

  logic [63:0]      ext_a, ext_b, product;
  logic             a_neg, b_neg;
  logic [31:0]      mag_a, mag_b, divisor, q_mag, r_mag, quot, rem;
  logic [31:0]      res_hi, res_lo;

  // ---------------------------------------------------------------- decode
  always_comb begin
    start_valid = (start == OP_MULT) || (start == OP_MULTU) ||
                  (start == OP_DIV)  || (start == OP_DIVU);
    start_ok    = (state == S_IDLE) && !flush && start_valid;
    // any nonzero start code, even a reserved one, takes priority over a move
    md_ok       = (state == S_IDLE) && !flush && (start == 3'd0) &&
                  ((MD == MD_MTHI) || (MD == MD_MTLO));
    is_mul      = (start == OP_MULT) || (start == OP_MULTU);
    signed_op   = (start == OP_MULT) || (start == OP_DIV);
    div_zero    = !is_mul && (B == 32'd0);
  end

  // ---------------------------------------------------------------- arithmetic
  always_comb begin
    ext_a   = {{32{A[31] & signed_op}}, A};
    ext_b   = {{32{B[31] & signed_op}}, B};
    product = ext_a * ext_b;
  end

  // Divide on magnitudes and fix signs afterwards; this also yields the
  // required 0x80000000 / -1 result without a special case.
  always_comb begin
    a_neg   = signed_op & A[31];
    b_neg   = signed_op & B[31];
    mag_a   = a_neg ? (32'd0 - A) : A;
    mag_b   = b_neg ? (32'd0 - B) : B;
    divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag   = mag_a / divisor;
    r_mag   = mag_a % divisor;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    res_hi = is_mul ? product[63:32] : rem;
    res_lo = is_mul ? product[31:0]  : quot;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start_ok) state_nxt = S_RUN;
      S_RUN:  if (cnt_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_last = (cnt == CNT_W'(1));
    busy     = (state == S_RUN);
    commit   = (state == S_RUN) && cnt_last;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start_ok) begin
      cnt <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (state == S_RUN) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_sh   <= '0;
      lo_sh   <= '0;
      skip_sh <= 1'b0;
    end else if (start_ok) begin
      hi_sh   <= res_hi;
      lo_sh   <= res_lo;
      skip_sh <= div_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (commit) begin
      if (!skip_sh) begin
        HI <= hi_sh;
        LO <= lo_sh;
      end
    end else if (md_ok) begin
      if (MD == MD_MTHI) HI <= A;
      if (MD == MD_MTLO) LO <= A;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: scoreboard of expected {HI,LO}
// pushed at issue time and compared when busy falls.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start;
  logic [1:0]  MD;
  logic        flush;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MD(MD), .flush(flush),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] s, input logic [1:0] md, input logic f,
                       input logic [31:0] a, input logic [31:0] b);
    start = s; MD = md; flush = f; A = a; B = b;
    step();
    start = 3'd0; MD = 2'd0; flush = 1'b0;
  endtask

  // Independent reference: 64-bit products and integer division.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb;
    int     si, sj;
    case (op)
      3'd1: begin
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        return 64'(sa * sb);
      end
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) return cur;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        si = signed'(a);
        sj = signed'(b);
        return {32'(si % sj), 32'(si / sj)};
      end
      3'd4: begin
        if (b == 32'd0) return cur;
        return {a % b, a / b};
      end
      default: return cur;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    e = model(op, a, b, {hi_m, lo_m});
    exp_q.push_back(e);
    hi_m = e[63:32];
    lo_m = e[31:0];
    drive(op, 2'd0, 1'b0, a, b);
  endtask

  // Counts busy cycles until busy drops; bounded so a stuck DUT still ends.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; MD = 0; flush = 0; A = 0; B = 0;
    repeat (3) step();
    reset = 1'b0;
    step();
    checks++;
    if ({busy, HI, LO} !== {1'b0, 64'd0})
      begin errors++; $display("FAIL reset_state: busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO); end
  endtask

  task automatic test_mult();
    int n;
    logic [63:0] e;
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_rise: busy=%b expected 1", busy); end
    wait_idle(n);
    checks++;
    if (n != 5) begin errors++; $display("FAIL mult_latency: got %0d cycles expected 5", n); end
    e = exp_q.pop_front();
    checks++;
    if ({HI, LO} !== e || e !== 64'hFFFF_FFFF_FFFF_FFFA)
      begin errors++; $display("FAIL mult_result: HI=%h LO=%h expected %h", HI, LO, e); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [63:0] e;
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    checks++;
    if (n != 5) begin errors++; $display("FAIL multu_latency: got %0d expected 5", n); end
    e = exp_q.pop_front();
    checks++;
    if ({HI, LO} !== 64'h0000_0001_FFFF_FFFE)
      begin errors++; $display("FAIL multu_result: HI=%h LO=%h expected %h", HI, LO, e); end
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b expected 1", busy); end
    wait_idle(n);
    checks++;
    if (n != 10) begin errors++; $display("FAIL div_latency: got %0d expected 10", n); end
    e = exp_q.pop_front();
    checks++;
    if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD)
      begin errors++; $display("FAIL div_result: HI=%h LO=%h expected %h", HI, LO, e); end
  endtask

  task automatic test_moves();
    int n;
    logic [63:0] e;
    drive(3'd0, 2'd1, 1'b0, 32'h1234_5678, 32'd0);
    hi_m = 32'h1234_5678;
    checks++;
    if ({busy, HI} !== {1'b0, 32'h1234_5678})
      begin errors++; $display("FAIL mthi: busy=%b HI=%h expected 0/12345678", busy, HI); end
    drive(3'd0, 2'd3, 1'b0, 32'h9ABC_DEF0, 32'd0);
    lo_m = 32'h9ABC_DEF0;
    checks++;
    if ({busy, HI, LO} !== {1'b0, hi_m, lo_m})
      begin errors++; $display("FAIL mtlo: busy=%b HI=%h LO=%h expected 0/%h/%h", busy, HI, LO, hi_m, lo_m); end
    drive(3'd0, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'd0);
    drive(3'd0, 2'd1, 1'b1, 32'hCAFE_F00D, 32'd0);
    step();
    checks++;
    if ({HI, LO} !== {hi_m, lo_m})
      begin errors++; $display("FAIL md_ignored: HI=%h LO=%h expected %h/%h", HI, LO, hi_m, lo_m); end
    issue(3'd4, 32'h0000_0064, 32'd0);
    wait_idle(n);
    checks++;
    if (n != 10) begin errors++; $display("FAIL divzero_latency: got %0d expected 10", n); end
    e = exp_q.pop_front();
    checks++;
    if ({HI, LO} !== 64'h1234_5678_9ABC_DEF0)
      begin errors++; $display("FAIL divzero_unchanged: HI=%h LO=%h expected %h", HI, LO, e); end
  endtask

  task automatic test_overflow_flush();
    int n;
    logic [63:0] e;
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    e = exp_q.pop_front();
    checks++;
    if ({HI, LO} !== 64'h0000_0000_8000_0000)
      begin errors++; $display("FAIL div_overflow: HI=%h LO=%h expected %h", HI, LO, e); end
    drive(3'd1, 2'd0, 1'b1, 32'd7, 32'd9);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_start: busy=%b expected 0", busy); end
    repeat (6) step();
    checks++;
    if ({HI, LO} !== {hi_m, lo_m})
      begin errors++; $display("FAIL flush_hold: HI=%h LO=%h expected %h/%h", HI, LO, hi_m, lo_m); end
  endtask

  task automatic test_reset_abort();
    drive(3'd3, 2'd0, 1'b0, 32'd100, 32'd7);
    repeat (3) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy4: busy=%b expected 1", busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    checks++;
    if ({busy, HI, LO} !== {1'b0, 64'd0})
      begin errors++; $display("FAIL abort_reset: busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO); end
    repeat (12) step();
    checks++;
    if ({busy, HI, LO} !== {1'b0, 64'd0})
      begin errors++; $display("FAIL abort_no_commit: busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO); end
    drive(3'd6, 2'd0, 1'b0, 32'd5, 32'd5);
    step();
    checks++;
    if ({busy, HI, LO} !== {1'b0, 64'd0})
      begin errors++; $display("FAIL reserved_op: busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO); end
  endtask

  task automatic test_busy_ignore();
    int n;
    logic [63:0] e;
    issue(3'd1, 32'd7, 32'hFFFF_FFFD);
    step();
    start = 3'd3; MD = 2'd1; A = 32'h5555_5555; B = 32'd1;
    step();
    start = 3'd0; MD = 2'd0;
    wait_idle(n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL ignore_latency: got %0d remaining expected 3", n); end
    e = exp_q.pop_front();
    checks++;
    if ({HI, LO} !== e || e !== 64'hFFFF_FFFF_FFFF_FFEB)
      begin errors++; $display("FAIL ignore_result: HI=%h LO=%h expected %h", HI, LO, e); end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: busy=%b expected 0", busy); end
  endtask

  task automatic test_random();
    int n;
    logic [63:0] e;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom();
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom() >> $urandom_range(0, 28);
      issue(op, a, b);
      wait_idle(n);
      e = exp_q.pop_front();
      checks++;
      if (n != ((op <= 3'd2) ? 5 : 10) || {HI, LO} !== e)
        begin errors++; $display("FAIL random_op%0d: op=%0d a=%h b=%h cycles=%0d HI=%h LO=%h expected %h", i, op, a, b, n, HI, LO, e); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_moves();
    test_overflow_flush();
    test_reset_abort();
    test_busy_ignore();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: %0d left expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
